tmds_channel_decoder: RTL and testbench

//  Receive end of one DVI TMDS lane: deserialises the 1-bit/tmds_clk stream produced by our

---
 rtl/tmds_channel_decoder.sv | 168 ++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: receive side of one DVI TMDS lane.
// Deserialises the bit stream, finds the 10-bit word alignment from repeated
// control tokens, and decodes every aligned word into DE/C0/C1/8-bit data.
// Optional feature macro: TMDS_DEC_STATS_EN adds a saturating lock-loss counter.
//
// state  | meaning
// HUNT   | no alignment; every window is compared against the token table
// VERIFY | candidate phase found; counting consecutive tokens on that phase
// LOCKED | aligned; every word boundary produces a decoded output word
module tmds_channel_decoder #(
  parameter int LOCK_TOKENS = 8,
  parameter int MAX_GAP     = 1023
) (
  input  logic       tmds_clk,
  input  logic       rst_n,
  input  logic       serial_in,
  output logic       locked,
  output logic       pix_valid,
  output logic       de,
  output logic       c0,
  output logic       c1,
  output logic [7:0] d
`ifdef TMDS_DEC_STATS_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  localparam logic [7:0]  LOCK_TOK_N = 8'(LOCK_TOKENS);
  localparam logic [15:0] GAP_MAX_N  = 16'(MAX_GAP);

  // Only the last nine bits are stored; the incoming bit completes the window.
  logic [8:0]  sr_q;
  logic [9:0]  w;
  logic [3:0]  phase_q, phase_nx;
  logic [7:0]  tok_cnt_q, tok_cnt_nx;
  logic [15:0] gap_q, gap_nx;
  state_t      state_q, state_nx;
  logic        is_tok;
  logic [1:0]  tok_c;
  logic [7:0]  x;
  logic [7:0]  data_dec;
  logic        boundary;
  logic        emit;

  assign w        = {sr_q, serial_in};
  assign boundary = (phase_q == 4'd9);

  // Control token lookup; tok_c is {c1, c0}.
  always_comb begin
    is_tok = 1'b1;
    tok_c  = 2'b00;
    case (w)
      10'b0010101011: tok_c = 2'b00;
      10'b1101010100: tok_c = 2'b01;
      10'b0010101010: tok_c = 2'b10;
      10'b1101010101: tok_c = 2'b11;
      default:        is_tok = 1'b0;
    endcase
  end

  // Data decode; with w[8]=0 our encoder inverts the whole XOR chain, so only bit 0 differs.
  always_comb begin
    x        = w[9] ? ~w[7:0] : w[7:0];
    data_dec = x ^ {x[6:0], 1'b0};
    if (!w[8]) data_dec[0] = ~x[0];
  end

  // Alignment FSM: next state, counters and the word-emit strobe.
  always_comb begin
    state_nx   = state_q;
    phase_nx   = boundary ? 4'd0 : phase_q + 4'd1;
    tok_cnt_nx = tok_cnt_q;
    gap_nx     = gap_q;
    emit       = 1'b0;
    case (state_q)
      HUNT: begin
        gap_nx = '0;
        if (is_tok) begin
          phase_nx   = 4'd0;
          tok_cnt_nx = 8'd1;
          state_nx   = VERIFY;
        end
      end
      VERIFY: begin
        gap_nx = '0;
        if (boundary) begin
          if (is_tok) begin
            tok_cnt_nx = tok_cnt_q + 8'd1;
            if (tok_cnt_q + 8'd1 == LOCK_TOK_N) state_nx = LOCKED;
          end else begin
            tok_cnt_nx = '0;
            state_nx   = HUNT;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          emit = 1'b1;
          if (is_tok) begin
            gap_nx = '0;
          end else if (gap_q + 16'd1 == GAP_MAX_N) begin
            gap_nx   = '0;
            state_nx = HUNT;
          end else begin
            gap_nx = gap_q + 16'd1;
          end
        end
      end
      default: state_nx = HUNT;
    endcase
  end

  // State, shift register and counters.
  always_ff @(posedge tmds_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      sr_q      <= '0;
      phase_q   <= '0;
      tok_cnt_q <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_nx;
      sr_q      <= w[8:0];
      phase_q   <= phase_nx;
      tok_cnt_q <= tok_cnt_nx;
      gap_q     <= gap_nx;
    end
  end

  // Registered outputs; decoded fields hold between strobes.
  always_ff @(posedge tmds_clk or negedge rst_n) begin
    if (!rst_n) begin
      locked    <= 1'b0;
      pix_valid <= 1'b0;
      de        <= 1'b0;
      c0        <= 1'b0;
      c1        <= 1'b0;
      d         <= '0;
    end else begin
      locked    <= (state_nx == LOCKED);
      pix_valid <= emit;
      if (emit) begin
        if (is_tok) begin
          de       <= 1'b0;
          {c1, c0} <= tok_c;
        end else begin
          de <= 1'b1;
          d  <= data_dec;
        end
      end
    end
  end

`ifdef TMDS_DEC_STATS_EN
  // Count lock losses, saturating at 255.
  always_ff @(posedge tmds_clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_loss_cnt <= '0;
    end else if (state_q == LOCKED && state_nx == HUNT && lock_loss_cnt != 8'hFF) begin
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: reset, lock acquisition, decode,
// lock loss on long data runs, mid-word reset and failed verification.
module tb_tmds_channel_decoder;

  localparam logic [9:0] T00  = 10'b0010101011;
  localparam logic [9:0] T01  = 10'b1101010100;
  localparam logic [9:0] T10  = 10'b0010101010;
  localparam logic [9:0] T11  = 10'b1101010101;
  localparam logic [9:0] D200 = 10'b0110111000;
  localparam logic [9:0] DFF  = 10'b1001010101;

  logic       tmds_clk = 1'b0;
  logic       rst_n;
  logic       serial_in;
  logic       locked, pix_valid, de, c0, c1;
  logic [7:0] d;
`ifdef TMDS_DEC_STATS_EN
  logic [7:0] lock_loss_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int pv_total    = 0;
  logic [9:0] wtmp;

  tmds_channel_decoder dut (
    .tmds_clk (tmds_clk),
    .rst_n    (rst_n),
    .serial_in(serial_in),
    .locked   (locked),
    .pix_valid(pix_valid),
    .de       (de),
    .c0       (c0),
    .c1       (c1),
    .d        (d)
`ifdef TMDS_DEC_STATS_EN
    ,
    .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  always #5 tmds_clk = ~tmds_clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bit, let the DUT clock it in, then sample just after the edge.
  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge tmds_clk);
    #1;
    if (pix_valid === 1'b1) pv_total++;
  endtask

  task automatic send_word(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_n(input logic [9:0] w, input int n);
    for (int k = 0; k < n; k++) send_word(w);
  endtask

  initial begin
    rst_n     = 1'b0;
    serial_in = 1'b0;
    @(posedge tmds_clk);
    #1;

    // Reset held: outputs stay zero whatever the line does.
    for (int i = 0; i < 6; i++) send_bit(i[0]);
    check("rst_locked", 16'(locked), 16'd0);
    check("rst_pix_valid", 16'(pix_valid), 16'd0);
    check("rst_de", 16'(de), 16'd0);
    check("rst_c0", 16'(c0), 16'd0);
    check("rst_c1", 16'(c1), 16'd0);
    check("rst_d", 16'(d), 16'd0);
`ifdef TMDS_DEC_STATS_EN
    check("rst_loss_cnt", 16'(lock_loss_cnt), 16'd0);
`endif

    // Junk bits, then lock on T00.
    rst_n = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    pv_total = 0;
    send_n(T00, 7);
    check("lock_after7", 16'(locked), 16'd0);
    send_word(T00);
    check("lock_after8", 16'(locked), 16'd1);
    check("no_pv_while_locking", 16'(pv_total), 16'd0);
    send_word(T00);
    check("tok00_pv", 16'(pix_valid), 16'd1);
    check("tok00_de", 16'(de), 16'd0);
    check("tok00_c", 16'({c1, c0}), 16'd0);

    // Data decode and one strobe per word.
    pv_total = 0;
    send_word(D200);
    check("d200_pv_count", 16'(pv_total), 16'd1);
    check("d200_de", 16'(de), 16'd1);
    check("d200_d", 16'(d), 16'd200);
    check("d200_c_hold", 16'({c1, c0}), 16'd0);
    send_word(DFF);
    check("dff_pv_count", 16'(pv_total), 16'd2);
    check("dff_d", 16'(d), 16'hFF);
    send_word(T01);
    check("tok01_de", 16'(de), 16'd0);
    check("tok01_c", 16'({c1, c0}), 16'd1);
    check("tok01_d_hold", 16'(d), 16'hFF);
    send_word(T10);
    check("tok10_c", 16'({c1, c0}), 16'd2);
    send_bit(1'b0);
    check("pv_one_cycle", 16'(pix_valid), 16'd0);
    send_n(10'b0, 0);
    for (int i = 8; i >= 0; i--) send_bit(T10[0] ^ 1'b0 ? 1'b0 : T10[i]);
    check("tok10_again_pv", 16'(pix_valid), 16'd1);

    // Data run with no tokens: lock drops on the 1023rd word.
    pv_total = 0;
    send_n(D200, 1022);
    check("gap1022_locked", 16'(locked), 16'd1);
    check("gap1022_pv_count", 16'(pv_total), 16'd1022);
    send_word(D200);
    check("gap1023_locked", 16'(locked), 16'd0);
    check("gap1023_pv", 16'(pix_valid), 16'd1);
    check("gap1023_d", 16'(d), 16'd200);
`ifdef TMDS_DEC_STATS_EN
    check("loss_cnt_1", 16'(lock_loss_cnt), 16'd1);
`endif
    pv_total = 0;
    send_n(T00, 7);
    check("relock_after7", 16'(locked), 16'd0);
    send_word(T00);
    check("relock_after8", 16'(locked), 16'd1);
    check("relock_no_pv", 16'(pv_total), 16'd0);
    send_word(T00);
    check("relock_pv", 16'(pix_valid), 16'd1);

    // Reset pulse in the middle of a word.
    wtmp = T00;
    for (int i = 9; i >= 5; i--) send_bit(wtmp[i]);
    rst_n = 1'b0;
    #1;
    check("midrst_locked", 16'(locked), 16'd0);
    check("midrst_d", 16'(d), 16'd0);
    check("midrst_pv", 16'(pix_valid), 16'd0);
    @(posedge tmds_clk);
    #1;
    rst_n = 1'b1;
    pv_total = 0;
    for (int i = 4; i >= 0; i--) send_bit(wtmp[i]);
    send_n(T11, 7);
    check("midrst_after7", 16'(locked), 16'd0);
    send_word(T11);
    check("midrst_after8", 16'(locked), 16'd1);
    check("midrst_no_pv", 16'(pv_total), 16'd0);
    send_word(T11);
    check("tok11_pv", 16'(pix_valid), 16'd1);
    check("tok11_c", 16'({c1, c0}), 16'd3);
`ifdef TMDS_DEC_STATS_EN
    check("loss_cnt_rst", 16'(lock_loss_cnt), 16'd0);
`endif

    // Seven tokens then data: verification fails and starts over.
    rst_n = 1'b0;
    @(posedge tmds_clk);
    #1;
    rst_n = 1'b1;
    pv_total = 0;
    send_n(T00, 7);
    send_word(D200);
    check("verify_fail_locked", 16'(locked), 16'd0);
    send_n(T00, 7);
    check("verify_restart7", 16'(locked), 16'd0);
    send_word(T00);
    check("verify_restart8", 16'(locked), 16'd1);
    check("verify_no_pv", 16'(pv_total), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
